test_pattern_sequencer: RTL

Pixel-source stage between display_timings and dvi_generator. It consumes the raster position, sync, DE and frame strobe, and generates one of four test patterns, one RGB888 pixel per pix_clk. It drives both DVI links identically, with sync and DE re-aligned to its pipeline latency. It also sequences patterns on frame boundaries, either on request or automatically, so mode changes never tear mid-frame.

---
 rtl/test_pattern_pkg.sv | 43 ++++
 rtl/test_pattern_sequencer_pattern_colour.sv | 72 +++++++
 rtl/test_pattern_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/test_pattern_pkg.sv
// Shared types and constants for the test pattern sequencer.
package test_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_GREY  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BAR   = 2'd3
    } mode_t;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    localparam int unsigned CNTW = 16;

    localparam rgb_t COL_WHITE     = 24'hFFFFFF;
    localparam rgb_t COL_YELLOW    = 24'hFFFF00;
    localparam rgb_t COL_CYAN      = 24'h00FFFF;
    localparam rgb_t COL_GREEN     = 24'h00FF00;
    localparam rgb_t COL_MAGENTA   = 24'hFF00FF;
    localparam rgb_t COL_RED       = 24'hFF0000;
    localparam rgb_t COL_BLUE      = 24'h0000FF;
    localparam rgb_t COL_BLACK     = 24'h000000;
    localparam rgb_t COL_DARK_BLUE = 24'h000040;

    // Colour of bar idx in the colour-bar pattern, left to right.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return COL_WHITE;
            3'd1:    return COL_YELLOW;
            3'd2:    return COL_CYAN;
            3'd3:    return COL_GREEN;
            3'd4:    return COL_MAGENTA;
            3'd5:    return COL_RED;
            3'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/test_pattern_sequencer_pattern_colour.sv
// Stage 2: turns the stage-1 pixel position and mode into a registered colour.
module pattern_colour
    import test_pattern_pkg::*;
#(
    parameter int unsigned H_RES = 1920,
    parameter int unsigned CORDW = 16,
    parameter int unsigned BAR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic                    de,
    input  mode_t                   mode,
    input  logic [CORDW-1:0]        bar_x,
    output rgb_t                    rgb
);

    localparam int unsigned BAR_PX = H_RES / 8;

    logic [CORDW-1:0] px;
    logic [2:0]       bar_idx;
    logic [7:0]       grey;
    logic             bar_hit;
    logic [CORDW:0]   bar_end;
    rgb_t             colour_c;
    logic             unused_sy;

    // Only bit 5 of the row matters for the checker.
    assign unused_sy = ^{sy[CORDW-1:6], sy[4:0]};
    assign px        = sx;
    assign bar_end   = {1'b0, bar_x} + (CORDW+1)'(BAR_W);

    // Colour-bar index from a ladder of threshold comparators.
    always_comb begin
        bar_idx = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (px >= CORDW'(BAR_PX * k)) bar_idx = 3'(k);
        end
    end

    // Grey ramp level: sx/8, clamped to full scale.
    always_comb begin
        grey = px[10:3];
        if (px[CORDW-1:11] != '0) grey = 8'hFF;
    end

    // Moving-bar window test.
    always_comb begin
        bar_hit = ({1'b0, px} >= {1'b0, bar_x}) && ({1'b0, px} < bar_end);
    end

    // Colour select; blanking and negative positions are black.
    always_comb begin
        colour_c = COL_BLACK;
        if (de && !sx[CORDW-1]) begin
            case (mode)
                MODE_BARS:  colour_c = bar_colour(bar_idx);
                MODE_GREY:  colour_c = {grey, grey, grey};
                MODE_CHECK: colour_c = (sx[5] ^ sy[5]) ? COL_WHITE : COL_BLACK;
                default:    colour_c = bar_hit ? COL_WHITE : COL_DARK_BLUE;
            endcase
        end
    end

    // Colour output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rgb <= COL_BLACK;
        else     rgb <= colour_c;
    end

endmodule

// File: rtl/test_pattern_sequencer.sv
// Test pattern source: mode sequencer, bar position, 2-stage pixel pipeline.
module test_pattern_sequencer
    import test_pattern_pkg::*;
#(
    parameter int unsigned H_RES           = 1920,
    parameter int unsigned V_RES           = 1080,
    parameter int unsigned CORDW           = 16,
    parameter int unsigned FRAMES_PER_MODE = 120,
    parameter int unsigned BAR_STEP        = 4,
    parameter int unsigned BAR_W           = 16
) (
    input  logic                    i_pix_clk,
    input  logic                    i_rst,
    input  logic signed [CORDW-1:0] i_sx,
    input  logic signed [CORDW-1:0] i_sy,
    input  logic                    i_de,
    input  logic                    i_hs,
    input  logic                    i_vs,
    input  logic                    i_frame,
    input  logic                    i_mode_next,
    input  logic                    i_auto,
    output logic [7:0]              o_red,
    output logic [7:0]              o_green,
    output logic [7:0]              o_blue,
    output logic                    o_de,
    output logic                    o_hs,
    output logic                    o_vs,
    output logic [1:0]              o_mode,
    output logic [CNTW-1:0]         o_frame_cnt
);

    // Elaboration-time parameter bounds.
    if (H_RES == 0 || (H_RES % 8) != 0) begin : g_bad_hres
        $error("H_RES must be a non-zero multiple of 8");
    end
    if (CORDW < 12 || H_RES >= 2**(CORDW-1)) begin : g_bad_cordw
        $error("CORDW too narrow for H_RES");
    end
    if (V_RES == 0 || V_RES >= 2**(CORDW-1)) begin : g_bad_vres
        $error("V_RES out of range for CORDW");
    end
    if (FRAMES_PER_MODE < 1 || FRAMES_PER_MODE > 65535) begin : g_bad_fpm
        $error("FRAMES_PER_MODE must be 1..65535");
    end

    mode_t                   mode, mode_n;
    logic [CNTW-1:0]         frame_cnt, frame_cnt_n;
    logic [CORDW-1:0]        bar_x, bar_x_n;
    logic [CORDW:0]          bar_sum;
    logic                    pending, pending_n;
    logic                    advance;

    logic signed [CORDW-1:0] s1_sx, s1_sy;
    logic                    s1_de, s1_hs, s1_vs;
    mode_t                   s1_mode;
    logic [CORDW-1:0]        s1_bar_x;
    rgb_t                    rgb;

    assign bar_sum = {1'b0, bar_x} + (CORDW+1)'(BAR_STEP);

    // Sequencer next state: requests collapse into pending, applied at frame start.
    always_comb begin
        mode_n      = mode;
        frame_cnt_n = frame_cnt;
        bar_x_n     = bar_x;
        pending_n   = pending | i_mode_next;
        advance     = pending | i_mode_next |
                      (i_auto && frame_cnt == CNTW'(FRAMES_PER_MODE - 1));
        if (i_frame) begin
            pending_n = 1'b0;
            if (advance) begin
                mode_n      = mode_t'(mode + 2'd1);
                frame_cnt_n = '0;
            end else if (frame_cnt != '1) begin
                frame_cnt_n = frame_cnt + CNTW'(1);
            end
            if (bar_sum >= (CORDW+1)'(H_RES)) bar_x_n = '0;
            else                              bar_x_n = bar_sum[CORDW-1:0];
        end
    end

    // Sequencer state register.
    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            mode      <= MODE_BARS;
            frame_cnt <= '0;
            bar_x     <= '0;
            pending   <= 1'b0;
        end else begin
            mode      <= mode_n;
            frame_cnt <= frame_cnt_n;
            bar_x     <= bar_x_n;
            pending   <= pending_n;
        end
    end

    // Stage 1: capture position, timing and the render state for this pixel.
    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_sx    <= '0;
            s1_sy    <= '0;
            s1_de    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_mode  <= MODE_BARS;
            s1_bar_x <= '0;
        end else begin
            s1_sx    <= i_sx;
            s1_sy    <= i_sy;
            s1_de    <= i_de;
            s1_hs    <= i_hs;
            s1_vs    <= i_vs;
            s1_mode  <= mode;
            s1_bar_x <= bar_x;
        end
    end

    // Stage 2 timing: DE and syncs line up with the colour register.
    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            o_de <= 1'b0;
            o_hs <= 1'b0;
            o_vs <= 1'b0;
        end else begin
            o_de <= s1_de;
            o_hs <= s1_hs;
            o_vs <= s1_vs;
        end
    end

    pattern_colour #(
        .H_RES (H_RES),
        .CORDW (CORDW),
        .BAR_W (BAR_W)
    ) u_colour (
        .clk   (i_pix_clk),
        .rst   (i_rst),
        .sx    (s1_sx),
        .sy    (s1_sy),
        .de    (s1_de),
        .mode  (s1_mode),
        .bar_x (s1_bar_x),
        .rgb   (rgb)
    );

    assign o_red       = rgb.red;
    assign o_green     = rgb.green;
    assign o_blue      = rgb.blue;
    assign o_mode      = mode;
    assign o_frame_cnt = frame_cnt;

endmodule
